// File: rtl/lib_cycle_timer_pkg.sv
// Shared op encodings and skid-buffer depth for the cycle timer.
package lib_cycle_timer_pkg;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_MARK    = 2'd1,
        OP_ELAPSED = 2'd2,
        OP_LAP     = 2'd3
    } op_e;

    localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/lib_cycle_timer_skid.sv
// Two-entry in-order output buffer; head entry is always presented on o_data.
module lib_cycle_timer_skid
    import lib_cycle_timer_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             i_clock,
    input  logic             i_resetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic [1:0]       r_count;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && (r_count != 2'(SKID_DEPTH));
    assign w_pop  = i_pop && (r_count != 2'd0);

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= i_data;
                    else                 r_tail <= i_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                // Push and pop together only happens at count 1: new entry becomes head.
                2'b11: r_head <= i_data;
                default: ;
            endcase
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_full  = (r_count == 2'(SKID_DEPTH));
    assign o_data  = r_head;

endmodule

// File: rtl/lib_cycle_timer.sv
// Free-running cycle timer with per-channel marks behind a valid/ready handshake.
// Define LIB_CYCLE_TIMER_SAT_EN to make the counter saturate instead of wrapping.
module lib_cycle_timer
    import lib_cycle_timer_pkg::*;
#(
    parameter int unsigned      WIDTH   = 64,
    parameter int unsigned      NCH     = 4,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(1)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             ivalid,
    input  logic             iready,
    output logic             ovalid,
    output logic             oready,
    input  logic [31:0]      op,
    input  logic [31:0]      chan,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_mark [NCH];

    op_e              w_op;
    logic             w_in_range;
    logic             w_accept;
    logic             w_mark_wr;
    logic             w_full;
    logic [WIDTH-1:0] w_mark;
    logic [WIDTH-1:0] w_res;
    logic             w_op_unused;

    assign w_op        = op_e'(op[1:0]);
    assign w_op_unused = ^op[31:2];
    assign w_in_range  = (chan < NCH);
    // resetn gates oready so it is low during reset and high right after release.
    assign oready      = resetn && !w_full;
    assign w_accept    = ivalid && oready;
    assign w_mark_wr   = ((w_op == OP_MARK) || (w_op == OP_LAP)) && w_in_range;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= RST_VAL;
        end else begin
`ifdef LIB_CYCLE_TIMER_SAT_EN
            if (r_cnt != '1) r_cnt <= r_cnt + WIDTH'(1);
`else
            r_cnt <= r_cnt + WIDTH'(1);
`endif
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NCH; i++) r_mark[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (w_accept && w_mark_wr && (chan == i)) r_mark[i] <= r_cnt;
            end
        end
    end

    always_comb begin
        w_mark = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (chan == i) w_mark = r_mark[i];
        end
    end

    always_comb begin
        w_res = '0;
        unique case (w_op)
            OP_READ:            w_res = r_cnt;
            OP_MARK:            w_res = w_in_range ? r_cnt : '0;
            OP_ELAPSED, OP_LAP: w_res = w_in_range ? (r_cnt - w_mark) : '0;
            default:            w_res = '0;
        endcase
    end

    lib_cycle_timer_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .i_clock  (clock),
        .i_resetn (resetn),
        .i_push   (w_accept),
        .i_data   (w_res),
        .i_pop    (iready),
        .o_valid  (ovalid),
        .o_full   (w_full),
        .o_data   (result)
    );

endmodule

// File: tb/tb_lib_cycle_timer.sv
// Directed self-checking bench for lib_cycle_timer at WIDTH=8, NCH=4.
module tb_lib_cycle_timer;

    localparam int unsigned W = 8;
    localparam int unsigned N = 4;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          ivalid = 1'b0;
    logic          iready = 1'b1;
    logic          ovalid;
    logic          oready;
    logic [31:0]   op = 32'd0;
    logic [31:0]   chan = 32'd0;
    logic [W-1:0]  result;

    logic [W-1:0]  m_cnt;
    int            n_chk = 0;
    int            n_fail = 0;

    lib_cycle_timer #(
        .WIDTH   (W),
        .NCH     (N),
        .RST_VAL (8'd1)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .ivalid (ivalid),
        .iready (iready),
        .ovalid (ovalid),
        .oready (oready),
        .op     (op),
        .chan   (chan),
        .result (result)
    );

    always #5 clock = ~clock;

    // Reference cycle count: value the DUT counter should hold in the current cycle.
    always @(posedge clock or negedge resetn) begin
        if (!resetn) m_cnt <= 8'd1;
`ifdef LIB_CYCLE_TIMER_SAT_EN
        else if (m_cnt != 8'hFF) m_cnt <= m_cnt + 8'd1;
`else
        else m_cnt <= m_cnt + 8'd1;
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge: present one request for a single edge, return what follows.
    task automatic do_req(input logic [31:0] o, input logic [31:0] c,
                          output logic [W-1:0] r, output logic v);
        ivalid = 1'b1;
        op     = o;
        chan   = c;
        @(negedge clock);
        ivalid = 1'b0;
        r      = result;
        v      = ovalid;
    endtask

    task automatic wait_cnt(input logic [W-1:0] t);
        int n = 0;
        while (m_cnt !== t && n < 600) begin
            @(negedge clock);
            n++;
        end
        n_chk++;
        if (m_cnt !== t) begin
            n_fail++;
            $display("FAIL wait_cnt: cnt %0d, never reached %0d", m_cnt, t);
        end
    endtask

    task automatic test_reset;
        logic [W-1:0] r;
        logic         v;
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        n_chk++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL rst_ovalid: got %b want 0", ovalid); end
        n_chk++; if (result !== 8'd0) begin n_fail++; $display("FAIL rst_result: got %0d want 0", result); end
        n_chk++; if (oready !== 1'b0) begin n_fail++; $display("FAIL rst_oready: got %b want 0", oready); end
        resetn = 1'b1;
        #1;
        n_chk++; if (oready !== 1'b1) begin n_fail++; $display("FAIL rel_oready: got %b want 1", oready); end
        do_req(32'd0, 32'd0, r, v);
        n_chk++; if (v !== 1'b1) begin n_fail++; $display("FAIL first_read_valid: got %b want 1", v); end
        n_chk++; if (r !== 8'd1) begin n_fail++; $display("FAIL first_read: got %0d want 1", r); end
        @(negedge clock);
        n_chk++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL first_read_pulse: got %b want 0", ovalid); end
    endtask

    task automatic test_timing;
        logic [W-1:0] r;
        logic         v;
        wait_cnt(8'd10);
        do_req(32'd1, 32'd2, r, v);
        n_chk++; if (v !== 1'b1 || r !== 8'd10) begin n_fail++; $display("FAIL mark_c2: got %0d/%b want 10/1", r, v); end
        wait_cnt(8'd25);
        do_req(32'd2, 32'd2, r, v);
        n_chk++; if (v !== 1'b1 || r !== 8'd15) begin n_fail++; $display("FAIL elapsed_c2: got %0d/%b want 15/1", r, v); end
        wait_cnt(8'd40);
        do_req(32'd3, 32'd2, r, v);
        n_chk++; if (r !== 8'd30) begin n_fail++; $display("FAIL lap_c2: got %0d want 30", r); end
        do_req(32'd2, 32'd2, r, v);
        n_chk++; if (v !== 1'b1 || r !== 8'd1) begin n_fail++; $display("FAIL lap_hazard: got %0d/%b want 1/1", r, v); end
    endtask

    task automatic test_out_of_range;
        logic [W-1:0] r;
        logic         v;
        wait_cnt(8'd50);
        do_req(32'd1, 32'd0, r, v);
        n_chk++; if (r !== 8'd50) begin n_fail++; $display("FAIL mark_c0: got %0d want 50", r); end
        wait_cnt(8'd60);
        do_req(32'd2, 32'd7, r, v);
        n_chk++; if (v !== 1'b1 || r !== 8'd0) begin n_fail++; $display("FAIL oor_elapsed: got %0d/%b want 0/1", r, v); end
        do_req(32'd1, 32'd7, r, v);
        n_chk++; if (r !== 8'd0) begin n_fail++; $display("FAIL oor_mark: got %0d want 0", r); end
        wait_cnt(8'd70);
        do_req(32'd2, 32'd0, r, v);
        n_chk++; if (r !== 8'd20) begin n_fail++; $display("FAIL c0_after_oor: got %0d want 20", r); end
        wait_cnt(8'd80);
        do_req(32'd2, 32'd2, r, v);
        n_chk++; if (r !== 8'd40) begin n_fail++; $display("FAIL c2_after_oor: got %0d want 40", r); end
        wait_cnt(8'd90);
        do_req(32'h0000_0104, 32'd9, r, v);
        n_chk++; if (r !== 8'd90) begin n_fail++; $display("FAIL read_upper_bits: got %0d want 90", r); end
    endtask

    task automatic test_wrap;
        logic [W-1:0] r;
        logic         v;
        wait_cnt(8'd250);
        do_req(32'd1, 32'd1, r, v);
        n_chk++; if (r !== 8'd250) begin n_fail++; $display("FAIL mark_c1: got %0d want 250", r); end
`ifdef LIB_CYCLE_TIMER_SAT_EN
        wait_cnt(8'd255);
        repeat (20) @(negedge clock);
        do_req(32'd2, 32'd1, r, v);
        n_chk++; if (r !== 8'd5) begin n_fail++; $display("FAIL sat_elapsed: got %0d want 5", r); end
        do_req(32'd0, 32'd0, r, v);
        n_chk++; if (r !== 8'd255) begin n_fail++; $display("FAIL sat_read: got %0d want 255", r); end
`else
        wait_cnt(8'd4);
        do_req(32'd2, 32'd1, r, v);
        n_chk++; if (r !== 8'd10) begin n_fail++; $display("FAIL wrap_elapsed: got %0d want 10", r); end
        do_req(32'd0, 32'd0, r, v);
        n_chk++; if (r !== 8'd5) begin n_fail++; $display("FAIL wrap_read: got %0d want 5", r); end
`endif
    endtask

    task automatic test_reset_midflight;
        logic [W-1:0] r;
        logic         v;
        iready = 1'b0;
        do_req(32'd0, 32'd0, r, v);
        do_req(32'd0, 32'd0, r, v);
        n_chk++; if (ovalid !== 1'b1 || oready !== 1'b0) begin n_fail++; $display("FAIL full_before_rst: got ovalid %b oready %b want 1 0", ovalid, oready); end
        #2 resetn = 1'b0;
        #1;
        n_chk++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL async_rst_ovalid: got %b want 0", ovalid); end
        n_chk++; if (result !== 8'd0 || oready !== 1'b0) begin n_fail++; $display("FAIL async_rst_out: got result %0d oready %b want 0 0", result, oready); end
        @(negedge clock);
        resetn = 1'b1;
        iready = 1'b1;
        #1;
        n_chk++; if (ovalid !== 1'b0 || oready !== 1'b1) begin n_fail++; $display("FAIL rel_empty: got ovalid %b oready %b want 0 1", ovalid, oready); end
        do_req(32'd2, 32'd0, r, v);
        n_chk++; if (v !== 1'b1 || r !== 8'd1) begin n_fail++; $display("FAIL rst_elapsed_c0: got %0d/%b want 1/1", r, v); end
        do_req(32'd2, 32'd2, r, v);
        n_chk++; if (r !== 8'd2) begin n_fail++; $display("FAIL rst_elapsed_c2: got %0d want 2", r); end
    endtask

    task automatic test_backpressure;
        wait_cnt(8'd5);
        iready = 1'b0;
        ivalid = 1'b1;
        op     = 32'd0;
        chan   = 32'd0;
        @(negedge clock);
        n_chk++; if (oready !== 1'b1 || ovalid !== 1'b1 || result !== 8'd5) begin n_fail++; $display("FAIL bp_one: got oready %b ovalid %b result %0d want 1 1 5", oready, ovalid, result); end
        @(negedge clock);
        n_chk++; if (oready !== 1'b0 || result !== 8'd5) begin n_fail++; $display("FAIL bp_full: got oready %b result %0d want 0 5", oready, result); end
        @(negedge clock);
        n_chk++; if (oready !== 1'b0 || ovalid !== 1'b1 || result !== 8'd5) begin n_fail++; $display("FAIL bp_hold: got oready %b ovalid %b result %0d want 0 1 5", oready, ovalid, result); end
        iready = 1'b1;
        @(negedge clock);
        n_chk++; if (oready !== 1'b1 || result !== 8'd6) begin n_fail++; $display("FAIL bp_drain6: got oready %b result %0d want 1 6", oready, result); end
        @(negedge clock);
        ivalid = 1'b0;
        n_chk++; if (ovalid !== 1'b1 || result !== 8'd9) begin n_fail++; $display("FAIL bp_third: got ovalid %b result %0d want 1 9", ovalid, result); end
        @(negedge clock);
        n_chk++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", ovalid); end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_out_of_range();
        test_wrap();
        test_reset_midflight();
        test_backpressure();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lib_cycle_timer.md
Name: lib_cycle_timer

Overview:
- Parametrised OpenCL-library cycle timer: WIDTH-bit free-running kernel-clock counter plus NCH per-channel mark registers.
- Exposes absolute timestamps, marks and elapsed-cycle queries through the standard ivalid/iready/ovalid/oready library handshake.
- Adds a 2-entry output skid buffer so it stalls correctly under downstream backpressure.
- Instantiated by kernels for in-kernel profiling: one call site per op.

Parameters:
- WIDTH, 64, counter/result width (64 maps to OpenCL ulong); legal 8..64.
- NCH, 4, number of mark channels; legal 1..32.
- RST_VAL, 1, counter value held during reset.

Ports:
- clock  in  1  kernel clock.
- resetn  in  1  asynchronous active-low reset.
- ivalid  in  1  upstream request valid.
- iready  in  1  downstream can accept result.
- ovalid  out  1  result valid.
- oready  out  1  block can accept request.
- op  in  32  operation; only bits [1:0] are decoded, upper bits ignored.
- chan  in  32  channel index; values >= NCH are out of range.
- result  out  WIDTH  timestamp or elapsed count.

Behaviour:
- Reset (async assert, any cycle, including mid-transfer):
  - cnt=RST_VAL, all marks=0, skid buffer emptied.
  - ovalid=0, result=0, oready=0 while resetn low.
  - oready=1 from the first cycle after deassert.
- Counter:
  - cnt increments by 1 on every rising edge with resetn high, independent of handshake and stalls.
  - Wraps modulo 2^WIDTH.
- Accept:
  - Request accepted on a rising edge with ivalid && oready.
  - Sampled value V = cnt as present in that cycle, i.e. before the increment.
- Ops on accept:
  - 0 READ: result=V.
  - 1 MARK: mark[chan]=V; result=V.
  - 2 ELAPSED: result=(V - mark[chan]) mod 2^WIDTH.
  - 3 LAP: result as ELAPSED, and mark[chan]=V in the same edge.
  - chan >= NCH: result=0, no mark written; READ ignores chan.
- Latency:
  - Result enters the skid buffer on the accept edge.
  - ovalid rises the next cycle if the buffer was empty. Minimum latency 1 cycle; throughput 1 per cycle while iready=1.
- Skid buffer:
  - 2-entry FIFO, strict in-order.
  - ovalid = count>0; result = head entry.
  - Pop on ovalid && iready.
  - oready = count<2, driven from registers only (no combinational path from iready or ivalid).
  - count==2: oready=0, no push. A pop in that cycle frees a slot for the next cycle.
  - Simultaneous push and pop at count 1: count stays 1, new entry queues behind head.
- Hazard: MARK/LAP followed by ELAPSED on the same chan in the next cycle must see the new mark (register write precedes read; no forwarding needed since accepts are one per edge).
- result holds its value while ovalid && !iready.

Optional Feature:
- Macro: LIB_CYCLE_TIMER_SAT_EN.
- Defined: cnt saturates at 2^WIDTH-1 and stays there until reset; ELAPSED/LAP arithmetic is unchanged (modular).
- Undefined: cnt wraps to 0 after 2^WIDTH-1.

Decomposition:
- Package lib_cycle_timer_pkg:
  - op encodings OP_READ=0, OP_MARK=1, OP_ELAPSED=2, OP_LAP=3.
  - skid depth constant SKID_DEPTH=2.
- Sub-module lib_cycle_timer_skid: parametrised-width 2-entry FIFO with count, push/pop, and the same async reset. The top level holds the counter, mark array and op decode.

Test Plan:
- Reset release, READ issued on the first edge after release (iready=1) -> result=1 one cycle later, ovalid pulse of 1 cycle.
- Two-step timing, NCH=4, chan=2:
  - MARK when cnt=10 -> result 10.
  - ELAPSED when cnt=25 -> result 15.
  - LAP when cnt=40 -> 30, then ELAPSED when cnt=41 -> 1.
- Wrap, WIDTH=8: MARK at cnt=250, ELAPSED at cnt=4 after wrap -> 10.
  - With LIB_CYCLE_TIMER_SAT_EN: cnt sticks at 255, and ELAPSED issued 20 cycles past saturation from mark 250 -> 5.
- Backpressure, iready=0, three back-to-back READs at cnt=5,6,7:
  - first two accepted, oready=0 on the third cycle, third held by upstream.
  - Raise iready -> results 5, 6 drained in order; the third READ is accepted later with its acceptance-cycle cnt.
- Out of range, NCH=4: chan=7 ELAPSED -> 0 and chan=7 MARK -> 0, with no mark change; a following ELAPSED on chan 0 is unaffected.
- Reset asserted with 2 entries buffered and ovalid=1 -> ovalid=0 immediately (async), buffer empty after release, marks 0, ELAPSED chan 0 returns V.
